axi_loopback_fifo: RTL and testbench
====================================

# axi_loopback_fifo

AXI4-Lite register-level loopback and bring-up block, next generation of the single-scratch loopback test block. Adds a parametrised scratch bank and a 32-bit word loopback FIFO, with level, full/empty and sticky error flags, plus a self-clearing soft reset. Sits on a processor AXI4-Lite port behind the codebase's `up_axi` bridge and is used to verify bus ordering, back-pressure and data integrity end to end.

## Interface
- `ID`, 0, value returned by the ID register.
- `AXI_ADDRESS_WIDTH`, 16, byte address width passed to `up_axi`; word address is `AXI_ADDRESS_WIDTH-2` bits.
- `NUM_SCRATCH`, 4, number of scratch registers, 1..32.
- `FIFO_DEPTH_LOG2`, 4, FIFO depth is 2^`FIFO_DEPTH_LOG2` words, 1..10.
- `s_axi_aclk` in 1: the single clock.
- `s_axi_areset` in 1: reset, asynchronous and active-high.
- `s_axi_aw*`, `s_axi_w*`, `s_axi_b*`, `s_axi_ar*`, `s_axi_r*`: standard AXI4-Lite slave, 32-bit data, `AXI_ADDRESS_WIDTH` address. `wstrb` and `*prot` are ignored. `bresp` and `rresp` are always 0.

## Operation
Word-address register map. Unmapped reads return 0. Unmapped writes are acknowledged and have no effect.
- 0x00 VERSION (RO) = 0x00020000.
- 0x01 ID (RO) = `ID`.
- 0x02 CONFIG (RO):
  - [7:0] = `NUM_SCRATCH`.
  - [15:8] = `FIFO_DEPTH_LOG2`.
- 0x10 STATUS:
  - [15:0] level, 0..depth.
  - [16] empty.
  - [17] full.
  - [18] overflow, sticky.
  - [19] underflow, sticky.
  - Writing 1 to bit 18 or bit 19 clears that flag. Other bits are RO.
- 0x11 PUSH (WO): appends wdata.
  - If full and no simultaneous pop: data is dropped, overflow is set, level is unchanged.
- 0x12 POP (RO): returns the head word and removes it.
  - If empty: returns 0 and sets underflow.
- 0x13 PEEK (RO): returns the head word without removing it; returns 0 if empty.
- 0x20 RESET (WO): writing bit0=1 issues a soft reset. Writing bit0=0 has no effect.
- 0x40..0x40+`NUM_SCRATCH`-1 SCRATCH[n] (RW): reset value is 0.

Soft reset clears FIFO pointers, level, sticky flags, stat counters and the scratch bank. It does not affect VERSION, ID or CONFIG. The asynchronous reset clears everything, including the `up_axi` handshake state.

FIFO storage is an inferred RAM with `FIFO_DEPTH_LOG2`-bit read and write pointers. Pointers wrap modulo depth. The level counter has `FIFO_DEPTH_LOG2+1` bits.

## Timing
- Write and read requests from `up_axi` are processed on independent channels and may coincide in the same cycle.
- `up_wack` asserts exactly 1 cycle after `up_wreq`. `up_rack` asserts exactly 1 cycle after `up_rreq`.
- Read data is registered and valid in the `up_rack` cycle; it is 0 in all other cycles.
- Register and FIFO state update on the clock edge that samples the request. A read issued the cycle after a write therefore sees the new value.
- Simultaneous PUSH and POP:
  - Non-empty FIFO: pop returns the old head, push appends, level is unchanged.
  - Full FIFO: both succeed and no overflow is flagged.
  - Empty FIFO: pop underflows and returns 0; push succeeds and level becomes 1.
- Soft reset takes effect at the edge sampling the RESET write. A POP in the same cycle returns the pre-reset head.
- Asserting `s_axi_areset` mid-transaction clears all outputs immediately: `awready`, `wready`, `bvalid`, `arready` and `rvalid` go to 0, and `rdata` goes to 0. An in-flight transaction is abandoned.

## Configuration
- `AXI_LOOPBACK_FIFO_STATS_EN` defined:
  - 0x14 PUSH_COUNT (RO) counts accepted pushes.
  - 0x15 POP_COUNT (RO) counts successful pops.
  - Both are 32-bit, wrap at 2^32 to 0, and are cleared by soft reset.
- Not defined: 0x14 and 0x15 read 0 and no counter logic is generated.

## Test plan
- After reset, read 0x00, 0x01, 0x10 → 0x00020000, `ID`, 0x00010000 (empty=1, level=0).
- Write 0xA5A5_0000+n to SCRATCH[n] for all n, then read them back → exact values. Write 1 to RESET → all scratch reads return 0.
- Push 1, 2, … up to depth words (default 16) → STATUS = 0x00020010. Push 0xDEAD once more → overflow bit 18 set, level still 16. POP ×16 → returns 1..16 in order. Extra POP → returns 0 and sets bit 19. Write 0x000C0000 to STATUS → both flags clear.
- Issue a concurrent PUSH of 0x55 and a POP on a FIFO holding the single word 0x11 → POP returns 0x11, next PEEK returns 0x55, level is 1.
- Assert `s_axi_areset` with 3 words queued and `rvalid` high → `rvalid` drops at once. After release, STATUS reads 0x00010000.
- With `AXI_LOOPBACK_FIFO_STATS_EN` defined: 5 pushes and 3 pops → 0x14 reads 5 and 0x15 reads 3. Without the macro, both read 0.

Source files
------------

// File: rtl/axi_loopback_fifo.sv
// AXI4-Lite loopback/bring-up block: ID/version registers, scratch bank and a 32-bit word FIFO.
// Define AXI_LOOPBACK_FIFO_STATS_EN to add the PUSH_COUNT/POP_COUNT statistics registers.
module axi_loopback_fifo #(
    parameter int ID                = 0,
    parameter int AXI_ADDRESS_WIDTH = 16,
    parameter int NUM_SCRATCH       = 4,
    parameter int FIFO_DEPTH_LOG2   = 4
) (
    input  logic                         s_axi_aclk,
    input  logic                         s_axi_areset,
    input  logic                         s_axi_awvalid,
    input  logic [AXI_ADDRESS_WIDTH-1:0] s_axi_awaddr,
    input  logic [2:0]                   s_axi_awprot,
    output logic                         s_axi_awready,
    input  logic                         s_axi_wvalid,
    input  logic [31:0]                  s_axi_wdata,
    input  logic [3:0]                   s_axi_wstrb,
    output logic                         s_axi_wready,
    output logic                         s_axi_bvalid,
    output logic [1:0]                   s_axi_bresp,
    input  logic                         s_axi_bready,
    input  logic                         s_axi_arvalid,
    input  logic [AXI_ADDRESS_WIDTH-1:0] s_axi_araddr,
    input  logic [2:0]                   s_axi_arprot,
    output logic                         s_axi_arready,
    output logic                         s_axi_rvalid,
    output logic [1:0]                   s_axi_rresp,
    output logic [31:0]                  s_axi_rdata,
    input  logic                         s_axi_rready
);

    localparam int AW    = AXI_ADDRESS_WIDTH - 2;
    localparam int PW    = FIFO_DEPTH_LOG2;
    localparam int LW    = FIFO_DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int SW    = (NUM_SCRATCH > 1) ? $clog2(NUM_SCRATCH) : 1;

    localparam logic [AW-1:0] A_VERSION = AW'('h00);
    localparam logic [AW-1:0] A_ID      = AW'('h01);
    localparam logic [AW-1:0] A_CONFIG  = AW'('h02);
    localparam logic [AW-1:0] A_STATUS  = AW'('h10);
    localparam logic [AW-1:0] A_PUSH    = AW'('h11);
    localparam logic [AW-1:0] A_POP     = AW'('h12);
    localparam logic [AW-1:0] A_PEEK    = AW'('h13);
    localparam logic [AW-1:0] A_PUSHCNT = AW'('h14);
    localparam logic [AW-1:0] A_POPCNT  = AW'('h15);
    localparam logic [AW-1:0] A_RESET   = AW'('h20);
    localparam logic [AW-1:0] A_SCRATCH = AW'('h40);

    typedef enum logic [2:0] {CH_IDLE, CH_REQ, CH_WAIT, CH_ACK, CH_RESP} ch_state_t;

    logic          up_clk;
    ch_state_t     w_state, w_next, r_state, r_next;
    logic          up_wreq, up_wack, up_rreq, up_rack;
    logic [AW-1:0] up_waddr, up_raddr;
    logic [31:0]   up_wdata, up_rdata, rdata_q, rd_mux;

    assign up_clk      = s_axi_aclk;
    assign s_axi_bresp = 2'b00;
    assign s_axi_rresp = 2'b00;

    logic unused_bits;
    assign unused_bits = ^{s_axi_awprot, s_axi_arprot, s_axi_wstrb, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    // AXI handshake: request, wait for ack, address/data ready pulse, then the response beat.
    always_ff @(posedge up_clk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            w_state <= CH_IDLE;
            r_state <= CH_IDLE;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            w_state <= w_next;
            r_state <= r_next;
        end
    end

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
        w_next        = w_state;
        r_next        = r_state;
        up_wreq       = 1'b0;
        up_rreq       = 1'b0;
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        s_axi_arready = 1'b0;
        s_axi_rvalid  = 1'b0;
        case (w_state)
            CH_IDLE: if (s_axi_awvalid && s_axi_wvalid) w_next = CH_REQ;
            CH_REQ:  begin up_wreq = 1'b1; w_next = CH_WAIT; end
            CH_WAIT: if (up_wack) w_next = CH_ACK;
            CH_ACK:  begin s_axi_awready = 1'b1; s_axi_wready = 1'b1; w_next = CH_RESP; end
            CH_RESP: begin s_axi_bvalid = 1'b1; if (s_axi_bready) w_next = CH_IDLE; end
            default: w_next = CH_IDLE;
        endcase
        case (r_state)
            CH_IDLE: if (s_axi_arvalid) r_next = CH_REQ;
            CH_REQ:  begin up_rreq = 1'b1; r_next = CH_WAIT; end
            CH_WAIT: if (up_rack) r_next = CH_ACK;
            CH_ACK:  begin s_axi_arready = 1'b1; r_next = CH_RESP; end
            CH_RESP: begin s_axi_rvalid = 1'b1; if (s_axi_rready) r_next = CH_IDLE; end
            default: r_next = CH_IDLE;
        endcase
    end

    always_ff @(posedge up_clk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            up_waddr <= '0;
            up_wdata <= '0;
            up_raddr <= '0;
            rdata_q  <= '0;
        end else begin
            if (w_state == CH_IDLE && s_axi_awvalid && s_axi_wvalid) begin
                up_waddr <= s_axi_awaddr[AXI_ADDRESS_WIDTH-1:2];
                up_wdata <= s_axi_wdata;
            end
            if (r_state == CH_IDLE && s_axi_arvalid) up_raddr <= s_axi_araddr[AXI_ADDRESS_WIDTH-1:2];
            if (r_state == CH_WAIT && up_rack) rdata_q <= up_rdata;
        end
    end

    assign s_axi_rdata = s_axi_rvalid ? rdata_q : 32'd0;

    // Register file and FIFO
    logic [31:0]   mem [DEPTH];
    logic [31:0]   scratch [NUM_SCRATCH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] level;
    logic          overflow, underflow;
    logic          empty, full, push_req, pop_req, push_ok, pop_ok, soft_rst, wr_status;
    logic [AW-1:0] w_off, r_off;
    logic          w_in_scratch, r_in_scratch;
    logic [31:0]   head;

    assign empty     = (level == '0);
    assign full      = (level == LW'(DEPTH));
    assign push_req  = up_wreq && (up_waddr == A_PUSH);
    assign pop_req   = up_rreq && (up_raddr == A_POP);
    assign pop_ok    = pop_req && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push_ok   = push_req && (!full || pop_ok);
    assign soft_rst  = up_wreq && (up_waddr == A_RESET) && up_wdata[0];
    assign wr_status = up_wreq && (up_waddr == A_STATUS);
    assign head      = empty ? 32'd0 : mem[rd_ptr];

    assign w_off        = up_waddr - A_SCRATCH;
    assign r_off        = up_raddr - A_SCRATCH;
    assign w_in_scratch = (up_waddr >= A_SCRATCH) && (w_off < AW'(NUM_SCRATCH));
    assign r_in_scratch = (up_raddr >= A_SCRATCH) && (r_off < AW'(NUM_SCRATCH));

`ifdef AXI_LOOPBACK_FIFO_STATS_EN
    logic [31:0] push_count, pop_count;

    always_ff @(posedge up_clk or posedge s_axi_areset) begin
        if (s_axi_areset || soft_rst) begin
            push_count <= '0;
            pop_count  <= '0;
        end else begin
            if (push_ok) push_count <= push_count + 32'd1;
            if (pop_ok)  pop_count  <= pop_count + 32'd1;
        end
    end
`endif

    always_comb begin
        rd_mux = '0;
        case (up_raddr)
            A_VERSION: rd_mux = 32'h0002_0000;
            A_ID:      rd_mux = 32'(ID);
            A_CONFIG:  rd_mux = {16'd0, 8'(FIFO_DEPTH_LOG2), 8'(NUM_SCRATCH)};
            A_STATUS:  rd_mux = {12'd0, underflow, overflow, full, empty, 16'(level)};
            A_POP, A_PEEK: rd_mux = head;
`ifdef AXI_LOOPBACK_FIFO_STATS_EN
            A_PUSHCNT: rd_mux = push_count;
            A_POPCNT:  rd_mux = pop_count;
`endif
            default:   if (r_in_scratch) rd_mux = scratch[r_off[SW-1:0]];
        endcase
    end

    // NOTE: FIFO storage has no reset so it maps onto RAM; pointers and level make stale words invisible.
    always_ff @(posedge up_clk) begin
        if (push_ok) mem[wr_ptr] <= up_wdata;
    end

    always_ff @(posedge up_clk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            up_wack   <= 1'b0;
            up_rack   <= 1'b0;
            up_rdata  <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            for (int i = 0; i < NUM_SCRATCH; i++) scratch[i] <= '0;
        end else begin
            up_wack  <= up_wreq;
            up_rack  <= up_rreq;
            up_rdata <= up_rreq ? rd_mux : 32'd0;
            if (soft_rst) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                level     <= '0;
                overflow  <= 1'b0;
                underflow <= 1'b0;
                for (int i = 0; i < NUM_SCRATCH; i++) scratch[i] <= '0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + PW'(1);
                if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
                level <= level + LW'(push_ok) - LW'(pop_ok);
                // Setting a sticky flag wins over clearing it in the same cycle.
                if (wr_status && up_wdata[18]) overflow <= 1'b0;
                if (wr_status && up_wdata[19]) underflow <= 1'b0;
                if (push_req && !push_ok) overflow <= 1'b1;
                if (pop_req && empty) underflow <= 1'b1;
                if (up_wreq && w_in_scratch) scratch[w_off[SW-1:0]] <= up_wdata;
            end
        end
    end

endmodule

// File: tb/tb_axi_loopback_fifo.sv
// Self-checking bench for axi_loopback_fifo: directed bring-up sequence plus randomized traffic
// against a queue-based reference model.
module tb_axi_loopback_fifo;

    localparam int          DEPTH       = 16;
    localparam int          NUM_SCRATCH = 4;
    localparam logic [31:0] ID_VAL      = 32'h0000_5A17;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_axi_awvalid = 1'b0, s_axi_wvalid = 1'b0, s_axi_arvalid = 1'b0;
    logic        s_axi_bready = 1'b1, s_axi_rready = 1'b1;
    logic [15:0] s_axi_awaddr = '0, s_axi_araddr = '0;
    logic [31:0] s_axi_wdata = '0;
    logic        s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid;
    logic [1:0]  s_axi_bresp, s_axi_rresp;
    logic [31:0] s_axi_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    axi_loopback_fifo #(.ID(ID_VAL), .AXI_ADDRESS_WIDTH(16), .NUM_SCRATCH(NUM_SCRATCH), .FIFO_DEPTH_LOG2(4)) dut (
        .s_axi_aclk(clk), .s_axi_areset(rst),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(3'b000), .s_axi_awready(s_axi_awready),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(4'hF), .s_axi_wready(s_axi_wready),
        .s_axi_bvalid(s_axi_bvalid), .s_axi_bresp(s_axi_bresp), .s_axi_bready(s_axi_bready),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_araddr(s_axi_araddr), .s_axi_arprot(3'b000), .s_axi_arready(s_axi_arready),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rresp(s_axi_rresp), .s_axi_rdata(s_axi_rdata), .s_axi_rready(s_axi_rready)
    );

    // Reference model: FIFO contents as a queue, flags and counters as plain variables.
    logic [31:0] q[$];
    logic [31:0] m_scr [NUM_SCRATCH];
    bit          m_ovf, m_udf;
    int unsigned m_pushes, m_pops;

    function automatic void m_reset();
        q.delete();
        m_ovf = 0; m_udf = 0; m_pushes = 0; m_pops = 0;
        for (int i = 0; i < NUM_SCRATCH; i++) m_scr[i] = '0;
    endfunction

    function automatic void m_push(input logic [31:0] d);
        if (q.size() < DEPTH) begin q.push_back(d); m_pushes++; end
        else m_ovf = 1;
    endfunction

    function automatic logic [31:0] m_pop();
        if (q.size() == 0) begin m_udf = 1; return 32'd0; end
        m_pops++;
        return q.pop_front();
    endfunction

    function automatic logic [31:0] m_head();
        return (q.size() == 0) ? 32'd0 : q[0];
    endfunction

    function automatic logic [31:0] m_status();
        return {12'd0, m_udf, m_ovf, q.size() == DEPTH, q.size() == 0, 16'(q.size())};
    endfunction

    function automatic logic [31:0] m_stat(input int unsigned v);
`ifdef AXI_LOOPBACK_FIFO_STATS_EN
        return v;
`else
        return 32'd0 & v;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Bus tasks start and end at 1 time unit after a rising edge.
    task automatic axi_write(input int unsigned waddr, input logic [31:0] data);
        int n = 0;
        s_axi_awaddr = 16'(waddr << 2); s_axi_wdata = data;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        do begin @(negedge clk); n++; end while (!s_axi_awready && n < 50);
        if (!s_axi_awready) check("aw_timeout", {31'd0, s_axi_awready}, 32'd1);
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        n = 0;
        while (!s_axi_bvalid && n < 50) begin @(negedge clk); n++; end
        if (!s_axi_bvalid) check("b_timeout", {31'd0, s_axi_bvalid}, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic axi_read(input int unsigned raddr, output logic [31:0] data);
        int n = 0;
        s_axi_araddr = 16'(raddr << 2);
        s_axi_arvalid = 1'b1;
        do begin @(negedge clk); n++; end while (!s_axi_arready && n < 50);
        if (!s_axi_arready) check("ar_timeout", {31'd0, s_axi_arready}, 32'd1);
        @(posedge clk); #1;
        s_axi_arvalid = 1'b0;
        n = 0;
        while (!s_axi_rvalid && n < 50) begin @(negedge clk); n++; end
        if (!s_axi_rvalid) check("r_timeout", {31'd0, s_axi_rvalid}, 32'd1);
        data = s_axi_rdata;
        @(posedge clk); #1;
    endtask

    task automatic read_check(input string tag, input int unsigned raddr, input logic [31:0] exp);
        logic [31:0] d;
        axi_read(raddr, d);
        check(tag, d, exp);
    endtask

    task automatic push(input logic [31:0] d);
        axi_write('h11, d);
        m_push(d);
    endtask

    task automatic pop_check(input string tag);
        logic [31:0] exp;
        exp = m_pop();
        read_check(tag, 'h12, exp);
    endtask

    // Write and read issued together so both requests reach the register file in one cycle.
    task automatic push_pop_check(input string tag, input logic [31:0] d);
        logic [31:0] got, exp;
        exp = m_pop();
        m_push(d);
        fork
            axi_write('h11, d);
            axi_read('h12, got);
        join
        check(tag, got, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        m_reset();
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d, got;
        int n;

        do_reset();
        check("rdata_idle", s_axi_rdata, 32'd0);
        read_check("version", 'h00, 32'h0002_0000);
        read_check("id", 'h01, ID_VAL);
        read_check("status_reset", 'h10, 32'h0001_0000);
        read_check("config", 'h02, {16'd0, 8'd4, 8'(NUM_SCRATCH)});

        // Scratch bank, unmapped accesses and soft reset
        for (int i = 0; i < NUM_SCRATCH; i++) begin
            axi_write('h40 + i, 32'hA5A5_0000 + i);
            m_scr[i] = 32'hA5A5_0000 + i;
        end
        for (int i = 0; i < NUM_SCRATCH; i++) read_check("scratch_rd", 'h40 + i, m_scr[i]);
        axi_write('h40 + NUM_SCRATCH, 32'hFFFF_FFFF);
        read_check("unmapped_scratch", 'h40 + NUM_SCRATCH, 32'd0);
        read_check("unmapped_30", 'h30, 32'd0);
        axi_write('h20, 32'hFFFF_FFFE);
        read_check("reset_bit0_zero", 'h40, m_scr[0]);
        axi_write('h20, 32'd1);
        m_reset();
        for (int i = 0; i < NUM_SCRATCH; i++) read_check("scratch_soft_rst", 'h40 + i, 32'd0);

        // Fill to full, overflow, drain, underflow, clear flags
        for (int i = 1; i <= DEPTH; i++) push(32'(i));
        read_check("status_full", 'h10, 32'h0002_0010);
        push(32'hDEAD);
        read_check("status_ovf", 'h10, m_status());
        read_check("peek_full", 'h13, 32'd1);
        for (int i = 1; i <= DEPTH; i++) pop_check("pop_order");
        pop_check("pop_empty");
        read_check("status_udf", 'h10, m_status());
        axi_write('h10, 32'h000C_0000);
        m_ovf = 0; m_udf = 0;
        read_check("status_clear", 'h10, 32'h0001_0000);
        read_check("peek_empty", 'h13, 32'd0);

        // Concurrent push/pop on one-deep, empty and full FIFOs
        push(32'h11);
        push_pop_check("pp_single", 32'h55);
        read_check("pp_peek", 'h13, 32'h55);
        read_check("pp_status", 'h10, m_status());
        pop_check("pp_drain");
        push_pop_check("pp_empty", 32'h77);
        read_check("pp_empty_status", 'h10, m_status());
        while (q.size() < DEPTH) push($urandom);
        push_pop_check("pp_full", 32'h99);
        read_check("pp_full_status", 'h10, m_status());

        // Soft reset together with a POP returns the pre-reset head
        d = m_head();
        fork
            axi_write('h20, 32'd1);
            axi_read('h12, got);
        join
        check("pop_with_soft_rst", got, d);
        m_reset();
        read_check("status_after_srst", 'h10, 32'h0001_0000);

        // Statistics counters
        for (int i = 0; i < 5; i++) push(32'h100 + i);
        for (int i = 0; i < 3; i++) pop_check("stat_pop");
        read_check("push_count", 'h14, m_stat(5));
        read_check("pop_count", 'h15, m_stat(3));

        // Randomized traffic against the model
        for (int it = 0; it < 300; it++) begin
            n = $urandom_range(0, 9);
            case (n)
                0, 1, 2: push($urandom);
                3:       pop_check("rnd_pop");
                4:       read_check("rnd_peek", 'h13, m_head());
                5:       read_check("rnd_status", 'h10, m_status());
                6:       push_pop_check("rnd_pushpop", $urandom);
                7: begin
                    d = $urandom;
                    axi_write('h10, d);
                    if (d[18]) m_ovf = 0;
                    if (d[19]) m_udf = 0;
                end
                8: begin
                    n = $urandom_range(0, NUM_SCRATCH - 1);
                    d = $urandom;
                    axi_write('h40 + n, d);
                    m_scr[n] = d;
                end
                default: begin
                    n = $urandom_range(0, NUM_SCRATCH - 1);
                    read_check("rnd_scratch", 'h40 + n, m_scr[n]);
                end
            endcase
        end
        read_check("rnd_push_count", 'h14, m_stat(m_pushes));
        read_check("rnd_pop_count", 'h15, m_stat(m_pops));

        // Asynchronous reset with a read response pending
        axi_write('h20, 32'd1);
        m_reset();
        for (int i = 0; i < 3; i++) push(32'hC0 + i);
        s_axi_rready = 1'b0;
        s_axi_araddr = 16'('h13 << 2);
        s_axi_arvalid = 1'b1;
        n = 0;
        while (!s_axi_rvalid && n < 50) begin @(negedge clk); n++; end
        check("arst_rvalid_before", {31'd0, s_axi_rvalid}, 32'd1);
        check("arst_rdata_before", s_axi_rdata, 32'hC0);
        #2 rst = 1'b1;
        #1;
        check("arst_rvalid", {31'd0, s_axi_rvalid}, 32'd0);
        check("arst_rdata", s_axi_rdata, 32'd0);
        check("arst_ready", {29'd0, s_axi_arready, s_axi_awready, s_axi_bvalid}, 32'd0);
        s_axi_arvalid = 1'b0;
        s_axi_rready = 1'b1;
        @(posedge clk); #1;
        do_reset();
        read_check("status_after_arst", 'h10, 32'h0001_0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
